// File: rtl/sram_arbiter.sv
// sram_arbiter: lets the 6502 bus (port 0) and the UART loader (port 1) share
// one external async SRAM. Each access runs IDLE -> SETUP -> ACCESS -> DONE,
// which gives the SRAM address/data setup, a write pulse of WAIT_CYC cycles
// and one cycle of hold. The grantee gets a one-cycle ack at the end.
module sram_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 2,
  parameter int RR       = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_dout_o,
  output logic          sram_we_o,
  input  logic [DW-1:0] sram_din_i,
  output logic          busy_o,
  output logic          owner_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          sram_we_q, sram_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          busy_q, busy_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          grant1;

  // Port 1 wins when it is the only requester, or when both ask and
  // round-robin says port 0 was served last.
  assign grant1 = (m0_req_i && m1_req_i) ? ((RR != 0) ? ~last_q : 1'b0)
                                         : m1_req_i;

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    sram_we_d  = sram_we_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    busy_d     = busy_q;
    owner_d    = owner_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          owner_d = grant1;
          last_d  = grant1;
          we_d    = grant1 ? m1_we_i    : m0_we_i;
          addr_d  = grant1 ? m1_addr_i  : m0_addr_i;
          dout_d  = grant1 ? m1_wdata_i : m0_wdata_i;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        sram_we_d = we_q;
        cnt_d     = 4'(WAIT_CYC - 1);
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          sram_we_d = 1'b0;
          state_d   = DONE;
          if (owner_q) begin
            m1_ack_d = 1'b1;
            if (!we_q) m1_rdata_d = sram_din_i;
          end else begin
            m0_ack_d = 1'b1;
            if (!we_q) m0_rdata_d = sram_din_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight without an ack.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      sram_we_q  <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      busy_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      sram_we_q  <= sram_we_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
    end
  end

  assign m0_ack_o    = m0_ack_q;
  assign m1_ack_o    = m1_ack_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign sram_addr_o = addr_q;
  assign sram_dout_o = dout_q;
  assign sram_we_o   = sram_we_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter. A transaction-level
// model decides who gets served and when the ack is due, pushes the expected
// result, and a monitor compares whenever an ack appears. A behavioural SRAM
// hangs off the pins so stored data can be compared at the end.
module tb_sram_arbiter;

  localparam int AW   = 19;
  localparam int DW   = 8;
  localparam int WAIT = 2;
  localparam int RRP  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0Req = 1'b0, m0We = 1'b0, m1Req = 1'b0, m1We = 1'b0;
  logic [AW-1:0] m0Addr = '0, m1Addr = '0;
  logic [DW-1:0] m0Wdata = '0, m1Wdata = '0;
  logic          m0Ack, m1Ack, sramWe, busy, owner;
  logic [DW-1:0] m0Rdata, m1Rdata, sramDout;
  logic [DW-1:0] sramDin = '0;
  logic [AW-1:0] sramAddr;

  typedef struct {
    int            ackCyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] refMem[logic [AW-1:0]];
  logic [DW-1:0] sramMem[logic [AW-1:0]];
  int            cyc = 0;
  int            nChecks = 0;
  int            nPass = 0;
  int            nextIdle = 0;
  bit            lastServed = 1'b1;
  logic [DW-1:0] lastRd[2];
  int            busyCnt = 0, weCnt = 0, firstWe = 0;

  sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT), .RR(RRP)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0Req), .m0_we_i(m0We), .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata),
    .m0_ack_o(m0Ack), .m0_rdata_o(m0Rdata),
    .m1_req_i(m1Req), .m1_we_i(m1We), .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata),
    .m1_ack_o(m1Ack), .m1_rdata_o(m1Rdata),
    .sram_addr_o(sramAddr), .sram_dout_o(sramDout), .sram_we_o(sramWe),
    .sram_din_i(sramDin), .busy_o(busy), .owner_o(owner)
  );

  // Free-running clock and a cycle counter shared by model and monitor.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Untouched SRAM locations read back a pattern derived from the address.
  function automatic logic [DW-1:0] defVal(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return refMem.exists(a) ? refMem[a] : defVal(a);
  endfunction

  function automatic logic [DW-1:0] sramRead(input logic [AW-1:0] a);
    return sramMem.exists(a) ? sramMem[a] : defVal(a);
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural SRAM: stores while the strobe is high, presents data for the
  // current address mid-cycle so the arbiter sees it at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sramWe) sramMem[sramAddr] = sramDout;
      sramDin = sramRead(sramAddr);
    end
  end

  // Reference model: whenever the arbiter is free and someone asks, pick the
  // winner by the arbitration rule, commit the access to the reference memory
  // and predict the ack cycle (SETUP, WAIT access cycles, then DONE).
  initial begin
    int   p;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        q0.delete();
        q1.delete();
        nextIdle   = cyc + 1;
        lastServed = 1'b1;
        lastRd[0]  = '0;
        lastRd[1]  = '0;
      end else if (cyc >= nextIdle && (m0Req || m1Req)) begin
        if (m0Req && m1Req) p = (RRP != 0) ? (lastServed ? 0 : 1) : 0;
        else p = m1Req ? 1 : 0;
        lastServed = (p == 1);
        e.we     = (p == 1) ? m1We    : m0We;
        e.addr   = (p == 1) ? m1Addr  : m0Addr;
        e.data   = (p == 1) ? m1Wdata : m0Wdata;
        e.ackCyc = cyc + WAIT + 2;
        if (e.we) begin
          refMem[e.addr] = e.data;
          e.rdata = lastRd[p];
        end else begin
          e.rdata   = refRead(e.addr);
          lastRd[p] = e.rdata;
        end
        nextIdle = cyc + WAIT + 3;
        if (p == 1) q1.push_back(e);
        else q0.push_back(e);
      end
    end
  end

  // Pops the oldest prediction for port p and compares it with what the
  // DUT shows during the ack cycle, including the SRAM pin timing.
  task automatic handleAck(input int p);
    exp_t          e;
    int            qs;
    logic [DW-1:0] rd, otherRd;
    qs      = (p == 1) ? q1.size() : q0.size();
    rd      = (p == 1) ? m1Rdata : m0Rdata;
    otherRd = (p == 1) ? m0Rdata : m1Rdata;
    checkOutput($sformatf("m%0d_ackExpected", p), qs, 1);
    if (qs > 0) begin
      e = (p == 1) ? q1.pop_front() : q0.pop_front();
      checkOutput($sformatf("m%0d_ackCycle", p), cyc, e.ackCyc);
      checkOutput($sformatf("m%0d_rdata", p), rd, e.rdata);
      checkOutput($sformatf("m%0d_otherRdata", p), otherRd, lastRd[1-p]);
      checkOutput($sformatf("m%0d_owner", p), owner, p);
      checkOutput($sformatf("m%0d_busyLen", p), busyCnt, WAIT + 2);
      checkOutput($sformatf("m%0d_weCycles", p), weCnt, e.we ? WAIT : 0);
      checkOutput($sformatf("m%0d_firstWe", p), firstWe, e.we ? 2 : 0);
      checkOutput($sformatf("m%0d_holdAddr", p), sramAddr, e.addr);
      if (e.we) checkOutput($sformatf("m%0d_holdData", p), sramDout, e.data);
    end
  endtask

  // Monitor: tracks busy length and strobe position, then checks each ack.
  initial begin
    forever begin
      @(negedge clk);
      if (!busy) begin
        busyCnt = 0;
        weCnt   = 0;
        firstWe = 0;
      end else begin
        busyCnt++;
        if (sramWe) begin
          weCnt++;
          if (firstWe == 0) firstWe = busyCnt;
        end
      end
      if (!reset) begin
        if (m0Ack) handleAck(0);
        if (m1Ack) handleAck(1);
      end
    end
  end

  // Drives one transaction from posedge+1, waits (bounded) for the ack, then
  // releases req at the edge that ends the ack cycle.
  task automatic applyStimulus(input int p, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, output int ackAt);
    int n;
    bit seen;
    if (p == 1) begin
      m1Req = 1'b1; m1We = we; m1Addr = a; m1Wdata = d;
    end else begin
      m0Req = 1'b1; m0We = we; m0Addr = a; m0Wdata = d;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen = (p == 1) ? m1Ack : m0Ack;
    end
    ackAt = cyc;
    checkOutput($sformatf("m%0d_ackArrived", p), seen, 1);
    @(posedge clk);
    #1;
    if (p == 1) m1Req = 1'b0;
    else m0Req = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sramWe"}, sramWe, 0);
    checkOutput({tag, "_sramAddr"}, sramAddr, 0);
    checkOutput({tag, "_sramDout"}, sramDout, 0);
    checkOutput({tag, "_m0Ack"}, m0Ack, 0);
    checkOutput({tag, "_m1Ack"}, m1Ack, 0);
    checkOutput({tag, "_m0Rdata"}, m0Rdata, 0);
    checkOutput({tag, "_m1Rdata"}, m1Rdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_owner"}, owner, 0);
  endtask

  function automatic logic [AW-1:0] randAddr();
    logic [3:0] low;
    low = 4'($urandom);
    return ($urandom_range(0, 1) == 1) ? (19'h7FFF0 | 19'(low)) : 19'(low);
  endfunction

  // Directed scenarios first, then random traffic on both ports, then a
  // reset in the middle of a write.
  initial begin
    int            a1, a2, nAck, n;
    logic [DW-1:0] rd0;
    lastRd[0] = '0;
    lastRd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;

    $display("[TB] read on port 0");
    refMem[19'h12345]  = 8'hA5;
    sramMem[19'h12345] = 8'hA5;
    applyStimulus(0, 1'b0, 19'h12345, 8'h00, a1);
    checkOutput("t1_m0Rdata", m0Rdata, 8'hA5);

    $display("[TB] write on port 1 at top address");
    applyStimulus(1, 1'b1, 19'h7FFFF, 8'h3C, a1);

    $display("[TB] back-to-back read then write on port 0");
    rd0 = refRead(19'h00000);
    applyStimulus(0, 1'b0, 19'h00000, 8'h00, a1);
    applyStimulus(0, 1'b1, 19'h00001, 8'hFF, a2);
    checkOutput("t6_ackSpacing", a2 - a1, WAIT + 3);
    checkOutput("t6_rdataKept", m0Rdata, rd0);

    $display("[TB] port 0 drops req during SETUP");
    m0Req = 1'b1; m0We = 1'b0; m0Addr = 19'h00ABC;
    @(posedge clk);
    #1;
    m0Req = 1'b0;
    nAck = 0;
    for (int i = 0; i < WAIT + 8; i++) begin
      @(posedge clk);
      #1;
      if (m0Ack) nAck++;
    end
    checkOutput("t5_ackCount", nAck, 1);

    $display("[TB] both ports contend with immediate re-requests");
    fork
      begin
        int t;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 19'(16 + i), 8'h00, t);
      end
      begin
        int t;
        for (int i = 0; i < 3; i++) applyStimulus(1, 1'b1, 19'(32 + i), 8'(i + 1), t);
      end
    join

    $display("[TB] random traffic");
    fork
      begin
        int t;
        for (int i = 0; i < 40; i++) begin
          applyStimulus(0, 1'($urandom), randAddr(), 8'($urandom), t);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        int t;
        for (int i = 0; i < 40; i++) begin
          applyStimulus(1, 1'($urandom), randAddr(), 8'($urandom), t);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join

    $display("[TB] reset during write access");
    m1Req = 1'b1; m1We = 1'b1; m1Addr = 19'h55555; m1Wdata = 8'h77;
    n = 0;
    while (!sramWe && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t4_strobeSeen", sramWe, 1);
    reset = 1'b1;
    m1Req = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("t4");
    reset = 1'b0;
    repeat (WAIT + 6) @(posedge clk);
    #1;

    checkOutput("q0Drained", q0.size(), 0);
    checkOutput("q1Drained", q1.size(), 0);
    foreach (refMem[a]) checkOutput($sformatf("mem_%0h", a), sramRead(a), refMem[a]);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Last-resort guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", nPass, nChecks + 1);
    $finish;
  end

endmodule
